// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 keyboard receiver with frame checks, watchdog,
// optional E0/F0 prefix folding and a first-word-fall-through code FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DECODE     = 1
) (
    input  logic                          iCLK_50,
    input  logic                          iKEY,
    input  logic                          iSW,
    input  logic                          PS2_KBCLK,
    input  logic                          PS2_KBDAT,
    input  logic                          iRD,
    output logic [9:0]                    oDATA,
    output logic                          oVALID,
    output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
    output logic                          oOVF,
    output logic [2:0]                    oERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t state;
    logic [1:0] kc_s, kd_s;
    logic [FILTER_LEN-1:0] sr;
    logic fclk, fe, bit_in;
    logic [3:0] cnt;
    logic [9:0] sh;
    logic [WW-1:0] wd;
    logic ext, brk;
    logic is_e0, is_f0, push, pop, full, wr;
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;

    assign bit_in = kd_s[1];
    assign fe = fclk && ~|sr;

    always_ff @(posedge iCLK_50) begin
        if (!iKEY) begin
            kc_s <= '1;
            kd_s <= '1;
            sr   <= '1;
            fclk <= 1'b1;
        end else begin
            kc_s <= {kc_s[0], PS2_KBCLK};
            kd_s <= {kd_s[0], PS2_KBDAT};
            sr   <= {sr[FILTER_LEN-2:0], kc_s[1]};
            fclk <= (&sr) ? 1'b1 : (~|sr) ? 1'b0 : fclk;
        end
    end

    assign is_e0 = (DECODE != 0) && sh[7:0] == 8'hE0;
    assign is_f0 = (DECODE != 0) && sh[7:0] == 8'hF0;
    assign push  = state == CHECK && oERR == 3'b000 && !is_e0 && !is_f0;

    // Frame errors are registered on the stop-bit strobe so they line up with CHECK.
    always_ff @(posedge iCLK_50) begin
        if (!iKEY) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            wd    <= '0;
            oERR  <= '0;
            ext   <= 1'b0;
            brk   <= 1'b0;
        end else begin
            oERR <= '0;
            wd   <= (fe || state != SHIFT) ? '0 : wd + 1'b1;
            case (state)
                IDLE: begin
                    if (fe && iSW && !bit_in) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (fe) begin
                        sh  <= {bit_in, sh[9:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == 4'd9) begin
                            state   <= CHECK;
                            oERR[1] <= ~bit_in;
                            oERR[0] <= bit_in & ~^sh[9:1];
                        end
                    end else if (wd == WD_MAX) begin
                        state   <= IDLE;
                        oERR[2] <= 1'b1;
                        ext     <= 1'b0;
                        brk     <= 1'b0;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    ext   <= oERR == 3'b000 && (is_e0 || (ext && is_f0));
                    brk   <= oERR == 3'b000 && (is_f0 || (brk && is_e0));
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oVALID = oCOUNT != '0;
    assign pop    = iRD && oVALID;
    assign full   = oCOUNT == FULL;
    assign wr     = push && (!full || pop);
    assign oDATA  = oVALID ? mem[rp] : '0;

    always_ff @(posedge iCLK_50) begin
        if (!iKEY) begin
            wp     <= '0;
            rp     <= '0;
            oCOUNT <= '0;
            oOVF   <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            oCOUNT <= oCOUNT + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
            if (push && !wr) oOVF <= 1'b1;
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (wr) mem[wp] <= {ext, brk, sh[7:0]};
    end
endmodule
